multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  in  1  rising-edge clock, sole clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  IR[31:26] from datapath.
REQ-005 func  in  6  IR[5:0] from datapath.
REQ-006 zero  in  1  combinational ALU zero flag.
REQ-007 reg_dst, pc_src, mem_to_reg, ALU_srcB  out  2 each  datapath mux selects.
REQ-008 reg_write, mem_read, mem_write, IorD, IR_write, ALU_srcA  out  1 each  datapath strobes/selects.
REQ-009 pc_write_input  out  1  PC load enable.
REQ-010 alu_op  out  3  ALU operation code.
REQ-011 instr_done  out  1  one-cycle pulse in the last state of every instruction.
REQ-012 illegal  out  1  one-cycle pulse in DECODE when opcode/func is unsupported.

Function
REQ-013 SHALL be a Moore FSM with states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR; all outputs decode from state, except pc_write_input in BRANCH.
REQ-014 Outputs default to 0 in every state unless listed below.
REQ-015 IDLE: all outputs 0; unconditional next state FETCH.
REQ-016 FETCH: IorD=0, mem_read=1, IR_write=1, ALU_srcA=0, ALU_srcB=01, alu_op=ADD, pc_src=00, pc_write_input=1; next state DECODE.
REQ-017 DECODE: ALU_srcA=0, ALU_srcB=11, alu_op=ADD (precomputes branch target); dispatch on opcode: 0x23/0x2B->MEM_ADDR, 0x00->R_EXEC (func 0x08->JR), 0x08/0x0A/0x0C->I_EXEC, 0x04->BRANCH, 0x02->JUMP, 0x03->JAL, any other->FETCH with illegal=1.
REQ-018 MEM_ADDR: ALU_srcA=1, ALU_srcB=10, alu_op=ADD; lw->MEM_RD, sw->MEM_WR.
REQ-019 MEM_RD: IorD=1, mem_read=1 ->MEM_WB; MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1 ->FETCH.
REQ-020 MEM_WR: IorD=1, mem_write=1 ->FETCH.
REQ-021 R_EXEC: ALU_srcA=1, ALU_srcB=00, alu_op from func (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT) ->R_WB; R_WB: reg_dst=01, mem_to_reg=00, reg_write=1 ->FETCH; an unsupported func goes DECODE->FETCH with illegal=1.
REQ-022 I_EXEC: ALU_srcA=1, ALU_srcB=10, alu_op ADD/SLT/AND for addi/slti/andi ->I_WB; I_WB: reg_dst=00, mem_to_reg=00, reg_write=1 ->FETCH.
REQ-023 BRANCH: ALU_srcA=1, ALU_srcB=00, alu_op=SUB, pc_src=10, pc_write_input=zero (same cycle) ->FETCH.
REQ-024 JUMP: pc_src=01, pc_write_input=1 ->FETCH.
REQ-025 JAL: reg_dst=10, mem_to_reg=10, reg_write=1, pc_src=01, pc_write_input=1 ->FETCH.
REQ-026 JR: pc_src=11, pc_write_input=1 ->FETCH.
REQ-027 Cycles FETCH-to-FETCH: lw 5; sw/R/I 4; beq/j/jal/jr 3; illegal 2.
REQ-028 instr_done SHALL be 1 in MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP, JAL and JR.
REQ-029 At most one of mem_read/mem_write SHALL be 1 in any cycle.

Reset
REQ-030 rst low SHALL force state=IDLE immediately, independent of clk; all outputs read 0 while rst is low.
REQ-031 Reset asserted mid-instruction SHALL abort it with no further strobes; FETCH follows one cycle after rst deasserts.

Configuration
REQ-032 Macro MULTICYCLE_JAL_JR_EN: when defined, the JAL and JR states and dispatch exist as specified.
REQ-033 When undefined, opcode 0x03 and R-type func 0x08 SHALL be treated as illegal (DECODE->FETCH, illegal=1), and reg_dst/mem_to_reg/pc_src never take value 10/11 except pc_src=10 in BRANCH.

Structure
REQ-034 Shared package mips_pkg SHALL hold the state enum, the opcode/func constants, the alu_op encodings (ADD=000, SUB=001, AND=010, OR=011, SLT=100) and the mux-select constants.
REQ-035 One sub-module alu_ctrl_decode SHALL map func to alu_op combinationally.

Verification
REQ-036 Reset low for 3 cycles, then release -> all outputs 0, IDLE for 1 cycle, then FETCH with mem_read=IR_write=pc_write_input=1.
REQ-037 opcode=0x23 -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB (reg_write=1, mem_to_reg=01), instr_done pulses exactly once, 5 cycles.
REQ-038 opcode=0x04 with zero=1 and then zero=0 -> pc_write_input=1 and 0 respectively in BRANCH, pc_src=10, 3 cycles.
REQ-039 opcode=0x00, func=0x2A -> alu_op=100 in R_EXEC, reg_dst=01 in R_WB; func=0x3F -> illegal pulse, FETCH after DECODE.
REQ-040 opcode=0x03 with MULTICYCLE_JAL_JR_EN defined -> JAL: reg_dst=10, mem_to_reg=10, pc_src=01; with the macro undefined -> illegal pulse.
REQ-041 rst pulsed low during MEM_RD -> outputs drop to 0 asynchronously, then IDLE->FETCH, no reg_write issued.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcode/func
// constants, ALU operation codes and datapath mux-select values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_ALUOUT = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

endpackage

// File: rtl/alu_ctrl_decode.sv
// R-type func -> ALU operation; func_ok flags the funcs that run through R_EXEC.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       func_ok
);

  always_comb begin
    alu_op  = ALU_ADD;
    func_ok = 1'b1;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: func_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath.
// Define MULTICYCLE_JAL_JR_EN to build the jal / jr paths; otherwise they decode as illegal.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic [1:0] reg_dst,
  output logic [1:0] pc_src,
  output logic [1:0] mem_to_reg,
  output logic [1:0] ALU_srcB,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       IorD,
  output logic       IR_write,
  output logic       ALU_srcA,
  output logic       pc_write_input,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, state_nxt;
  logic [2:0] r_alu_op;
  logic       r_func_ok;

  alu_ctrl_decode u_alu_dec (
    .func    (func),
    .alu_op  (r_alu_op),
    .func_ok (r_func_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = S_FETCH;
    reg_dst        = 2'b00;
    pc_src         = 2'b00;
    mem_to_reg     = 2'b00;
    ALU_srcB       = 2'b00;
    reg_write      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    IorD           = 1'b0;
    IR_write       = 1'b0;
    ALU_srcA       = 1'b0;
    pc_write_input = 1'b0;
    alu_op         = ALU_ADD;
    instr_done     = 1'b0;
    illegal        = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_read       = 1'b1;
        IR_write       = 1'b1;
        ALU_srcB       = SRCB_FOUR;
        pc_src         = PC_ALU;
        pc_write_input = 1'b1;
        state_nxt      = S_DECODE;
      end
      S_DECODE: begin
        // ALU speculatively forms the branch target while the opcode is decoded
        ALU_srcB = SRCB_SHIMM;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
          OP_RTYPE: begin
`ifdef MULTICYCLE_JAL_JR_EN
            if (func == FN_JR)  state_nxt = S_JR;
            else
`endif
            if (r_func_ok)      state_nxt = S_R_EXEC;
            else                illegal   = 1'b1;
          end
          OP_ADDI, OP_SLTI, OP_ANDI: state_nxt = S_I_EXEC;
          OP_BEQ: state_nxt = S_BRANCH;
          OP_J:   state_nxt = S_JUMP;
`ifdef MULTICYCLE_JAL_JR_EN
          OP_JAL: state_nxt = S_JAL;
`endif
          default: illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        ALU_srcA  = 1'b1;
        ALU_srcB  = SRCB_IMM;
        state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD      = 1'b1;
        mem_read  = 1'b1;
        state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_dst    = REG_DST_RT;
        mem_to_reg = WB_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        ALU_srcA  = 1'b1;
        ALU_srcB  = SRCB_REG;
        alu_op    = r_alu_op;
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = REG_DST_RD;
        mem_to_reg = WB_ALU;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ALU_srcA  = 1'b1;
        ALU_srcB  = SRCB_IMM;
        case (opcode)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
        state_nxt = S_I_WB;
      end
      S_I_WB: begin
        reg_dst    = REG_DST_RT;
        mem_to_reg = WB_ALU;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // the only Mealy term: PC loads in the compare cycle itself
        ALU_srcA       = 1'b1;
        ALU_srcB       = SRCB_REG;
        alu_op         = ALU_SUB;
        pc_src         = PC_ALUOUT;
        pc_write_input = zero;
        instr_done     = 1'b1;
      end
      S_JUMP: begin
        pc_src         = PC_JUMP;
        pc_write_input = 1'b1;
        instr_done     = 1'b1;
      end
`ifdef MULTICYCLE_JAL_JR_EN
      S_JAL: begin
        reg_dst        = REG_DST_RA;
        mem_to_reg     = WB_PC;
        reg_write      = 1'b1;
        pc_src         = PC_JUMP;
        pc_write_input = 1'b1;
        instr_done     = 1'b1;
      end
      S_JR: begin
        pc_src         = PC_REG;
        pc_write_input = 1'b1;
        instr_done     = 1'b1;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver expands each instruction into its expected per-cycle
// output trace; a negedge monitor pops one entry per cycle and compares.
module tb_multicycle_controller;

  typedef struct packed {
    logic [1:0] reg_dst, pc_src, mem_to_reg, srcb;
    logic       reg_write, mem_read, mem_write, iord, ir_write, srca, pcw;
    logic [2:0] alu_op;
    logic       done, illegal;
  } obs_t;

`ifdef MULTICYCLE_JAL_JR_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0, func = '0;
  logic       zero = 1'b0;
  logic [1:0] reg_dst, pc_src, mem_to_reg, ALU_srcB;
  logic       reg_write, mem_read, mem_write, IorD, IR_write, ALU_srcA, pc_write_input;
  logic [2:0] alu_op;
  logic       instr_done, illegal;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .reg_dst(reg_dst), .pc_src(pc_src), .mem_to_reg(mem_to_reg), .ALU_srcB(ALU_srcB),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .IorD(IorD),
    .IR_write(IR_write), .ALU_srcA(ALU_srcA), .pc_write_input(pc_write_input),
    .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  obs_t act;
  assign act = {reg_dst, pc_src, mem_to_reg, ALU_srcB, reg_write, mem_read, mem_write,
                IorD, IR_write, ALU_srcA, pc_write_input, alu_op, instr_done, illegal};

  obs_t exp_q[$];
  int   checks = 0, passed = 0;

  always @(negedge clk) begin
    obs_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL cycle_unexpected t=%0t actual=%h required=<no cycle>", $time, act);
    end else begin
      e = exp_q.pop_front();
      if (act === e) passed++;
      else $display("FAIL cycle_trace t=%0t actual=%h required=%h", $time, act, e);
    end
  end

  // Reference model: the spec's per-instruction step lists, one record per cycle.
  function automatic obs_t step(string s, logic z, logic [2:0] alu, logic ill);
    obs_t o = '0;
    case (s)
      "fetch":  begin o.mem_read = 1; o.ir_write = 1; o.srcb = 2'b01; o.pcw = 1; end
      "decode": begin o.srcb = 2'b11; o.illegal = ill; end
      "addr":   begin o.srca = 1; o.srcb = 2'b10; end
      "rd":     begin o.iord = 1; o.mem_read = 1; end
      "lwwb":   begin o.mem_to_reg = 2'b01; o.reg_write = 1; o.done = 1; end
      "wr":     begin o.iord = 1; o.mem_write = 1; o.done = 1; end
      "rexec":  begin o.srca = 1; o.alu_op = alu; end
      "rwb":    begin o.reg_dst = 2'b01; o.reg_write = 1; o.done = 1; end
      "iexec":  begin o.srca = 1; o.srcb = 2'b10; o.alu_op = alu; end
      "iwb":    begin o.reg_write = 1; o.done = 1; end
      "beq":    begin o.srca = 1; o.alu_op = 3'b001; o.pc_src = 2'b10; o.pcw = z; o.done = 1; end
      "j":      begin o.pc_src = 2'b01; o.pcw = 1; o.done = 1; end
      "jal":    begin o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.reg_write = 1;
                      o.pc_src = 2'b01; o.pcw = 1; o.done = 1; end
      "jr":     begin o.pc_src = 2'b11; o.pcw = 1; o.done = 1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int keep, output int n);
    obs_t t[$];
    t.push_back(step("fetch", 0, 0, 0));
    case (op)
      6'h23: begin t.push_back(step("decode",0,0,0)); t.push_back(step("addr",0,0,0));
                   t.push_back(step("rd",0,0,0)); t.push_back(step("lwwb",0,0,0)); end
      6'h2B: begin t.push_back(step("decode",0,0,0)); t.push_back(step("addr",0,0,0));
                   t.push_back(step("wr",0,0,0)); end
      6'h00: begin
        if (fn == 6'h08 && JAL_EN) begin
          t.push_back(step("decode",0,0,0)); t.push_back(step("jr",0,0,0));
        end else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
          logic [2:0] a;
          a = (fn == 6'h20) ? 3'd0 : (fn == 6'h22) ? 3'd1 : (fn == 6'h24) ? 3'd2 :
              (fn == 6'h25) ? 3'd3 : 3'd4;
          t.push_back(step("decode",0,0,0)); t.push_back(step("rexec",0,a,0));
          t.push_back(step("rwb",0,0,0));
        end else t.push_back(step("decode",0,0,1));
      end
      6'h08, 6'h0A, 6'h0C: begin
        t.push_back(step("decode",0,0,0));
        t.push_back(step("iexec",0,(op == 6'h08) ? 3'd0 : (op == 6'h0A) ? 3'd4 : 3'd2,0));
        t.push_back(step("iwb",0,0,0));
      end
      6'h04: begin t.push_back(step("decode",0,0,0)); t.push_back(step("beq",z,0,0)); end
      6'h02: begin t.push_back(step("decode",0,0,0)); t.push_back(step("j",0,0,0)); end
      6'h03: begin
        if (JAL_EN) begin t.push_back(step("decode",0,0,0)); t.push_back(step("jal",0,0,0)); end
        else t.push_back(step("decode",0,0,1));
      end
      default: t.push_back(step("decode",0,0,1));
    endcase
    n = (keep > 0 && keep < t.size()) ? keep : t.size();
    for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
  endtask

  // Called with the DUT in FETCH, one time unit after the edge that entered it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int n;
    opcode = op; func = fn; zero = z;
    model(op, fn, z, 0, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (act === '0) passed++;
    else $display("FAIL async_reset_zero t=%0t actual=%h required=0", $time, act);
    // two cycles in reset plus the IDLE cycle, all outputs quiet
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('0);
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [5:0] op, fn;
    #2;
    do_reset();

    run_instr(6'h23, 6'h00, 0);
    run_instr(6'h2B, 6'h11, 0);
    run_instr(6'h04, 6'h00, 1);
    run_instr(6'h04, 6'h00, 0);
    run_instr(6'h00, 6'h2A, 0);
    run_instr(6'h00, 6'h3F, 0);
    run_instr(6'h03, 6'h00, 0);
    run_instr(6'h00, 6'h08, 0);
    run_instr(6'h02, 6'h00, 0);
    run_instr(6'h0A, 6'h00, 0);
    run_instr(6'h3F, 6'h20, 0);

    // abort a lw in MEM_RD
    opcode = 6'h23; func = 6'h00;
    model(6'h23, 6'h00, 0, 4, n);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    do_reset();

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: op = 6'h23;
        1: op = 6'h2B;
        2, 3: op = 6'h00;
        4: op = ($urandom_range(0, 2) == 0) ? 6'h08 : ($urandom_range(0, 1) == 0) ? 6'h0A : 6'h0C;
        5: op = 6'h04;
        6: op = 6'h02;
        7: op = 6'h03;
        default: op = 6'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h2A;
        5: fn = 6'h08;
        default: fn = 6'($urandom);
      endcase
      run_instr(op, fn, 1'($urandom));
    end

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL trace_drained actual=%0d required=0 pending", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
